// File: rtl/min_index_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : min_index_pkg                                              |
// | Brief   : Width helpers for the pipelined arg-min tree: stage count, |
// |           index widths and per-level survivor counts/offsets.        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package min_index_pkg;

   // Smallest r such that 2**r >= value (0 for value <= 1).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   function automatic int max1(input int value);
      return (value < 1) ? 1 : value;
   endfunction

   // Number of registered compare levels needed to reduce n costs to one.
   function automatic int tree_stages(input int n);
      return clog2(n);
   endfunction

   // Width of the global index group*N + local.
   function automatic int index_width(input int n, input int groups);
      return max1(clog2(n * groups));
   endfunction

   function automatic int group_width(input int groups);
      return max1(clog2(groups));
   endfunction

   function automatic int local_width(input int n);
      return max1(clog2(n));
   endfunction

   // Survivors entering level s: ceil(n / 2**s), identical to repeated ceil halving.
   function automatic int level_count(input int n, input int s);
      return (n + (1 << s) - 1) >> s;
   endfunction

   // Position of level s inside the flattened all-levels bus.
   function automatic int level_offset(input int n, input int s);
      int sum;
      sum = 0;
      for (int t = 0; t < s; t++) sum += level_count(n, t);
      return sum;
   endfunction

endpackage
`default_nettype wire

// File: rtl/min_index_tree_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : min_index_tree_if                                        |
// | Brief     : Cost beat in, arg-min result out.                        |
// | Rev       : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface min_index_tree_if #(
   parameter int N          = 12,
   parameter int W          = 28,
   parameter int MAX_GROUPS = 1
);
   import min_index_pkg::*;

   localparam int c_iw = index_width(N, MAX_GROUPS);

   logic              iValid;
   logic              iLast;
   logic [N*W-1:0]    iIn;
   logic              oValid;
   logic [c_iw-1:0]   oMinimum;
   logic [W-1:0]      oValue;
   logic              oOverflow;

   modport master (
      output iValid, iLast, iIn,
      input  oValid, oMinimum, oValue, oOverflow
   );

   modport slave (
      input  iValid, iLast, iIn,
      output oValid, oMinimum, oValue, oOverflow
   );

endinterface
`default_nettype wire

// File: rtl/min_index_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : min_index_stage                                             |
// | Brief  : One registered pairwise-reduce level of the arg-min tree.   |
// |          M survivors in, ceil(M/2) out; odd leftover passes through. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module min_index_stage #(
   parameter int M  = 2,
   parameter int W  = 8,
   parameter int XW = 1
) (
   input  logic                      iClock,
   input  logic                      iReset,
   input  logic                      iEnable,
   input  logic                      iValid,
   input  logic                      iLast,
   input  logic [M*W-1:0]            iValues,
   input  logic [M*XW-1:0]           iIndices,
   output logic                      oValid,
   output logic                      oLast,
   output logic [((M+1)/2)*W-1:0]    oValues,
   output logic [((M+1)/2)*XW-1:0]   oIndices
);

   localparam int c_q = (M + 1) / 2;

   logic [c_q*W-1:0]  w_values;
   logic [c_q*XW-1:0] w_indices;
   logic              r_valid;
   logic              r_last;
   logic [c_q*W-1:0]  r_values;
   logic [c_q*XW-1:0] r_indices;

   for (genvar j = 0; j < M / 2; j++) begin : g_pair
      logic [W-1:0] w_left;
      logic [W-1:0] w_right;
      logic         w_right_wins;

      assign w_left       = iValues[2*j*W +: W];
      assign w_right      = iValues[(2*j+1)*W +: W];
      // Strict compare: on a tie the left (lower) index survives.
      assign w_right_wins = (w_right < w_left);
      assign w_values[j*W +: W]    = w_right_wins ? w_right : w_left;
      assign w_indices[j*XW +: XW] = w_right_wins ? iIndices[(2*j+1)*XW +: XW]
                                                  : iIndices[2*j*XW +: XW];
   end

   if ((M % 2) != 0) begin : g_odd
      assign w_values[(c_q-1)*W +: W]    = iValues[(M-1)*W +: W];
      assign w_indices[(c_q-1)*XW +: XW] = iIndices[(M-1)*XW +: XW];
   end

   // Level register; last is only meaningful on a valid beat.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
         r_values  <= '0;
         r_indices <= '0;
      end else if (iEnable) begin
         r_valid   <= iValid;
         r_last    <= iValid & iLast;
         r_values  <= w_values;
         r_indices <= w_indices;
      end
   end

   assign oValid   = r_valid;
   assign oLast    = r_last;
   assign oValues  = r_values;
   assign oIndices = r_indices;

endmodule
`default_nettype wire

// File: rtl/min_index_tree.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : min_index_tree                                              |
// | Brief  : Pipelined arg-min over N costs per beat with an optional    |
// |          running minimum across up to MAX_GROUPS beats per search.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module min_index_tree #(
   parameter int N          = 12,
   parameter int W          = 28,
   parameter int MAX_GROUPS = 1
) (
   input  logic             iClock,
   input  logic             iReset,
   input  logic             iEnable,
   min_index_tree_if.slave  bus
);
   import min_index_pkg::*;

   localparam int c_l     = tree_stages(N);
   localparam int c_iw    = index_width(N, MAX_GROUPS);
   localparam int c_gw    = group_width(MAX_GROUPS);
   localparam int c_lw    = local_width(N);
   localparam int c_total = level_offset(N, c_l + 1);
   localparam int c_root  = level_offset(N, c_l);

   localparam logic [c_iw-1:0] c_n_iw      = c_iw'(N);
   localparam logic [c_gw-1:0] c_grp_max   = c_gw'(MAX_GROUPS - 1);

   // All tree levels flattened: level 0 is the raw beat, level c_l the single winner.
   logic [c_total*W-1:0]    w_lvl_values;
   logic [c_total*c_lw-1:0] w_lvl_indices;
   logic [c_l:0]            w_lvl_valid;
   logic [c_l:0]            w_lvl_last;

   assign w_lvl_values[N*W-1:0] = bus.iIn;
   assign w_lvl_valid[0]        = bus.iValid;
   assign w_lvl_last[0]         = bus.iLast;

   for (genvar k = 0; k < N; k++) begin : g_leaf
      assign w_lvl_indices[k*c_lw +: c_lw] = c_lw'(k);
   end

   for (genvar s = 0; s < c_l; s++) begin : g_level
      localparam int c_m   = level_count(N, s);
      localparam int c_q   = level_count(N, s + 1);
      localparam int c_in  = level_offset(N, s);
      localparam int c_out = level_offset(N, s + 1);

      min_index_stage #(
         .M  (c_m),
         .W  (W),
         .XW (c_lw)
      ) u_stage (
         .iClock   (iClock),
         .iReset   (iReset),
         .iEnable  (iEnable),
         .iValid   (w_lvl_valid[s]),
         .iLast    (w_lvl_last[s]),
         .iValues  (w_lvl_values[c_in*W +: c_m*W]),
         .iIndices (w_lvl_indices[c_in*c_lw +: c_m*c_lw]),
         .oValid   (w_lvl_valid[s+1]),
         .oLast    (w_lvl_last[s+1]),
         .oValues  (w_lvl_values[c_out*W +: c_q*W]),
         .oIndices (w_lvl_indices[c_out*c_lw +: c_q*c_lw])
      );
   end

   logic [W-1:0]    w_tree_value;
   logic [c_lw-1:0] w_tree_index;
   logic            w_tree_valid;
   logic            w_tree_last;
   logic [c_iw-1:0] w_cand_index;
   logic            w_first;
   logic            w_take;

   logic [W-1:0]    r_acc_value;
   logic [c_iw-1:0] r_acc_index;
   logic [c_gw-1:0] r_grp;
   logic            r_ovf;
   logic            r_out_valid;
   logic [c_iw-1:0] r_out_index;
   logic [W-1:0]    r_out_value;
   logic            r_out_ovf;

   assign w_tree_value = w_lvl_values[c_root*W +: W];
   assign w_tree_index = w_lvl_indices[c_root*c_lw +: c_lw];
   assign w_tree_valid = w_lvl_valid[c_l];
   assign w_tree_last  = w_lvl_last[c_l];

   assign w_cand_index = (c_iw'(r_grp) * c_n_iw) + c_iw'(w_tree_index);
   // With MAX_GROUPS=1 grp never leaves 0, so the overflow flag is what marks
   // later beats of an over-long search as no longer the first.
   assign w_first      = (r_grp == '0) && !r_ovf;
   assign w_take       = w_first || (w_tree_value < r_acc_value);

   // Running minimum across groups; publishes and re-arms on the last beat.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         r_acc_value <= '1;
         r_acc_index <= '0;
         r_grp       <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_index <= '0;
         r_out_value <= '0;
         r_out_ovf   <= 1'b0;
      end else if (iEnable) begin
         r_out_valid <= 1'b0;
         if (w_tree_valid) begin
            if (w_tree_last) begin
               r_out_valid <= 1'b1;
               r_out_index <= w_take ? w_cand_index : r_acc_index;
               r_out_value <= w_take ? w_tree_value : r_acc_value;
               r_out_ovf   <= r_ovf;
               r_acc_value <= '1;
               r_acc_index <= '0;
               r_grp       <= '0;
               r_ovf       <= 1'b0;
            end else begin
               if (w_take) begin
                  r_acc_value <= w_tree_value;
                  r_acc_index <= w_cand_index;
               end
               if (r_grp == c_grp_max) begin
                  r_ovf <= 1'b1;
               end else begin
                  r_grp <= r_grp + 1'b1;
               end
            end
         end
      end
   end

   assign bus.oValid    = r_out_valid;
   assign bus.oMinimum  = r_out_index;
   assign bus.oValue    = r_out_value;
   assign bus.oOverflow = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_min_index_tree.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_min_index_tree                                           |
// | Brief  : Scoreboard bench for min_index_tree in three configurations |
// |          (N=12/W=28/G=1, N=5/W=8/G=1, N=4/W=16/G=4).                 |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_min_index_tree;
   import min_index_pkg::*;

   localparam int c_n0 = 12, c_w0 = 28, c_g0 = 1;
   localparam int c_n1 = 5,  c_w1 = 8,  c_g1 = 1;
   localparam int c_n2 = 4,  c_w2 = 16, c_g2 = 4;

   logic iClock = 1'b0;
   logic iReset;
   logic iEnable;

   always #5 iClock = ~iClock;

   min_index_tree_if #(.N(c_n0), .W(c_w0), .MAX_GROUPS(c_g0)) bus0 ();
   min_index_tree_if #(.N(c_n1), .W(c_w1), .MAX_GROUPS(c_g1)) bus1 ();
   min_index_tree_if #(.N(c_n2), .W(c_w2), .MAX_GROUPS(c_g2)) bus2 ();

   min_index_tree #(.N(c_n0), .W(c_w0), .MAX_GROUPS(c_g0)) dut0 (
      .iClock (iClock), .iReset (iReset), .iEnable (iEnable), .bus (bus0));
   min_index_tree #(.N(c_n1), .W(c_w1), .MAX_GROUPS(c_g1)) dut1 (
      .iClock (iClock), .iReset (iReset), .iEnable (iEnable), .bus (bus1));
   min_index_tree #(.N(c_n2), .W(c_w2), .MAX_GROUPS(c_g2)) dut2 (
      .iClock (iClock), .iReset (iReset), .iEnable (iEnable), .bus (bus2));

   typedef struct {
      int     cfg;
      longint idx;
      longint value;
      longint ovf;
      longint edge_no;
   } exp_t;

   exp_t   sb[$];
   longint beats[$];
   int     nbeats = 0;
   longint vals[16];
   int     errors = 0;
   int     checks = 0;
   longint en_edges = 0;
   longint cyc = 0;
   logic   en_prev = 1'b0;
   logic   rst_prev = 1'b1;

   // Count enabled, non-reset edges: the unit in which latency is measured.
   always @(posedge iClock) begin
      cyc      <= cyc + 1;
      en_prev  <= iEnable;
      rst_prev <= iReset;
      if (iEnable && !iReset) en_edges <= en_edges + 1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic observe(input int c, input logic [63:0] idx, input logic [63:0] value,
                          input logic [63:0] ovf);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL spurious_ovalid: cfg%0d got index %0d, expected no output", c, idx);
      end else begin
         e = sb.pop_front();
         check($sformatf("cfg%0d_config", c), 64'(c), 64'(e.cfg));
         check($sformatf("cfg%0d_index", c), idx, e.idx);
         check($sformatf("cfg%0d_value", c), value, e.value);
         check($sformatf("cfg%0d_overflow", c), ovf, e.ovf);
         check($sformatf("cfg%0d_latency_edge", c), en_edges, e.edge_no);
      end
   endtask

   // Monitor: a result is new only when the edge that produced it was enabled.
   always @(negedge iClock) begin
      if (en_prev && !rst_prev) begin
         if (bus0.oValid === 1'b1)
            observe(0, 64'(bus0.oMinimum), 64'(bus0.oValue), 64'(bus0.oOverflow));
         if (bus1.oValid === 1'b1)
            observe(1, 64'(bus1.oMinimum), 64'(bus1.oValue), 64'(bus1.oOverflow));
         if (bus2.oValid === 1'b1)
            observe(2, 64'(bus2.oMinimum), 64'(bus2.oValue), 64'(bus2.oOverflow));
      end
   end

   function automatic int cfg_n(input int c);
      return (c == 0) ? c_n0 : (c == 1) ? c_n1 : c_n2;
   endfunction
   function automatic int cfg_w(input int c);
      return (c == 0) ? c_w0 : (c == 1) ? c_w1 : c_w2;
   endfunction
   function automatic int cfg_g(input int c);
      return (c == 0) ? c_g0 : (c == 1) ? c_g1 : c_g2;
   endfunction

   // Reference: scan all costs of the search in arrival order, keep the first strict minimum.
   task automatic expect_search(input int c, input longint edge_no);
      exp_t   e;
      int     n, g, grp;
      longint v;
      n = cfg_n(c);
      g = cfg_g(c);
      e.cfg = c;
      e.idx = 0;
      e.value = 0;
      for (int b = 0; b < nbeats; b++) begin
         grp = (b < g) ? b : g - 1;
         for (int k = 0; k < n; k++) begin
            v = beats[b*n + k];
            if ((b == 0 && k == 0) || v < e.value) begin
               e.value = v;
               e.idx   = longint'(grp * n + k);
            end
         end
      end
      e.ovf     = (nbeats > g) ? 1 : 0;
      e.edge_no = edge_no;
      sb.push_back(e);
      beats.delete();
      nbeats = 0;
   endtask

   task automatic drive_bus(input int c, input logic valid, input logic last);
      case (c)
         0: begin
            bus0.iValid = valid;
            bus0.iLast  = last;
            for (int k = 0; k < c_n0; k++) bus0.iIn[k*c_w0 +: c_w0] = c_w0'(vals[k]);
         end
         1: begin
            bus1.iValid = valid;
            bus1.iLast  = last;
            for (int k = 0; k < c_n1; k++) bus1.iIn[k*c_w1 +: c_w1] = c_w1'(vals[k]);
         end
         default: begin
            bus2.iValid = valid;
            bus2.iLast  = last;
            for (int k = 0; k < c_n2; k++) bus2.iIn[k*c_w2 +: c_w2] = c_w2'(vals[k]);
         end
      endcase
   endtask

   // One beat, consumed at the next edge; a last beat books its expected result.
   task automatic beat(input int c, input logic last);
      int n;
      n = cfg_n(c);
      iEnable = 1'b1;
      for (int k = 0; k < n; k++) beats.push_back(vals[k] & ((longint'(1) << cfg_w(c)) - 1));
      nbeats++;
      drive_bus(c, 1'b1, last);
      if (last) expect_search(c, en_edges + 1 + longint'(tree_stages(n)));
      @(posedge iClock);
      #1;
      drive_bus(c, 1'b0, 1'b0);
   endtask

   // Idle cycles with iLast toggling under iValid=0, optionally with random stalls.
   task automatic idle(input int cycles, input bit allow_stall);
      repeat (cycles) begin
         iEnable = allow_stall ? 1'($urandom_range(0, 1)) : 1'b1;
         for (int c = 0; c < 3; c++) drive_bus(c, 1'b0, 1'($urandom_range(0, 1)));
         @(posedge iClock);
         #1;
      end
      iEnable = 1'b1;
      for (int c = 0; c < 3; c++) drive_bus(c, 1'b0, 1'b0);
   endtask

   task automatic fill_random(input int c);
      int     mode;
      longint mask;
      longint base;
      mask = (longint'(1) << cfg_w(c)) - 1;
      mode = $urandom_range(0, 3);
      base = longint'($urandom_range(0, 9));
      for (int k = 0; k < cfg_n(c); k++) begin
         case (mode)
            0:       vals[k] = longint'($urandom) & mask;
            1:       vals[k] = longint'($urandom_range(0, 7));
            2:       vals[k] = ($urandom_range(0, 1) == 1) ? mask : longint'($urandom_range(0, 3));
            default: vals[k] = base;
         endcase
      end
   endtask

   task automatic set4(input longint a, input longint b, input longint c, input longint d);
      vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
   endtask

   // Stimulus and directed scenarios.
   initial begin
      longint c0;
      longint obs_cyc;
      bit     got;
      int     nb;

      iReset  = 1'b1;
      iEnable = 1'b1;
      for (int k = 0; k < 16; k++) vals[k] = 0;
      for (int c = 0; c < 3; c++) drive_bus(c, 1'b0, 1'b0);
      repeat (3) @(posedge iClock);
      #1;
      iReset = 1'b0;
      @(negedge iClock);
      check("rst_ovalid0", 64'(bus0.oValid), 0);
      check("rst_omin0", 64'(bus0.oMinimum), 0);
      check("rst_oval0", 64'(bus0.oValue), 0);
      check("rst_oovf0", 64'(bus0.oOverflow), 0);
      check("rst_ovalid1", 64'(bus1.oValid), 0);
      check("rst_oval1", 64'(bus1.oValue), 0);
      check("rst_ovalid2", 64'(bus2.oValid), 0);
      check("rst_omin2", 64'(bus2.oMinimum), 0);
      @(posedge iClock);
      #1;

      // Plain 12-way min: k -> 100-k gives index 11, value 89.
      for (int k = 0; k < c_n0; k++) vals[k] = 100 - k;
      beat(0, 1'b1);
      idle(8, 0);

      // Back-to-back ties: all 7, then 3 and 9 equal, then all-ones everywhere.
      for (int k = 0; k < c_n0; k++) vals[k] = 7;
      beat(0, 1'b1);
      for (int k = 0; k < c_n0; k++) vals[k] = (k == 3 || k == 9) ? 5 : 50;
      beat(0, 1'b1);
      for (int k = 0; k < c_n0; k++) vals[k] = (longint'(1) << c_w0) - 1;
      beat(0, 1'b1);
      idle(8, 0);

      // Two stall cycles mid-pipeline push the result out by exactly two cycles.
      for (int k = 0; k < c_n0; k++) vals[k] = 100 - k;
      c0 = cyc;
      beat(0, 1'b1);
      idle(1, 0);
      iEnable = 1'b0;
      repeat (2) begin
         @(posedge iClock);
         #1;
      end
      iEnable = 1'b1;
      got = 1'b0;
      obs_cyc = 0;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge iClock);
         if (bus0.oValid === 1'b1) begin
            got = 1'b1;
            obs_cyc = cyc;
         end
      end
      check("stall_result_seen", 64'(got), 1);
      check("stall_delay_cycles", obs_cyc - c0, 7);
      @(posedge iClock);
      #1;
      idle(4, 0);

      // Odd N=5: winner sits in the pass-through slot.
      vals[0] = 9; vals[1] = 8; vals[2] = 7; vals[3] = 6; vals[4] = 2;
      beat(1, 1'b1);
      idle(6, 0);

      // Multi-group: tie at value 5 keeps the earlier group.
      set4(40, 41, 42, 43); beat(2, 1'b0);
      set4(30, 31, 5, 33);  beat(2, 1'b0);
      set4(5, 9, 9, 9);     beat(2, 1'b1);
      idle(5, 0);
      // Five beats overflow; the winning beat arrives on the saturated group.
      for (int b = 0; b < 5; b++) begin
         set4(20 - b, 50, 50, 50);
         beat(2, (b == 4));
      end
      // Exactly MAX_GROUPS beats, then a single-beat search.
      for (int b = 0; b < 4; b++) begin
         set4(60, 61 - b, 62, 63);
         beat(2, (b == 3));
      end
      set4(7, 3, 3, 9); beat(2, 1'b1);
      idle(6, 0);

      // Reset mid-search: aborted beats leave no result and grp restarts.
      set4(1, 1, 1, 1); beat(2, 1'b0);
      set4(2, 2, 2, 2); beat(2, 1'b0);
      iReset = 1'b1;
      @(posedge iClock);
      #1;
      iReset = 1'b0;
      beats.delete();
      nbeats = 0;
      @(negedge iClock);
      check("midrst_omin0", 64'(bus0.oMinimum), 0);
      check("midrst_oval0", 64'(bus0.oValue), 0);
      check("midrst_ovalid2", 64'(bus2.oValid), 0);
      @(posedge iClock);
      #1;
      set4(1, 2, 3, 0); beat(2, 1'b1);
      idle(6, 0);

      // Randomised searches with random stalls between beats.
      for (int i = 0; i < 30; i++) begin
         fill_random(0);
         beat(0, 1'b1);
         idle($urandom_range(0, 2), 1);
      end
      for (int i = 0; i < 15; i++) begin
         fill_random(1);
         beat(1, 1'b1);
         idle($urandom_range(0, 2), 1);
      end
      for (int i = 0; i < 25; i++) begin
         nb = $urandom_range(1, 6);
         for (int b = 0; b < nb; b++) begin
            fill_random(2);
            beat(2, (b == nb - 1));
            idle($urandom_range(0, 1), 1);
         end
      end

      for (int t = 0; t < 200 && sb.size() > 0; t++) begin
         @(posedge iClock);
         #1;
      end
      idle(4, 0);
      check("scoreboard_drained", 64'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/min_index_tree.md
Name: min_index_tree

Overview:
- Parametrised pipelined arg-min selector for the hardware encoder.
- Picks the smallest of N unsigned W-bit costs presented in parallel, e.g. residual bit counts per Rice parameter or per predictor order.
- Optionally tracks a running minimum across several consecutive beats (groups) up to an iLast marker, so a candidate set larger than N can be searched serially.
- Reports the winning global index and its value with a valid pulse; sits between the cost calculators and the encoder parameter-selection logic.

Parameters:
- N, 12, number of parallel inputs per beat; N >= 2.
- W, 28, width of each unsigned cost value.
- MAX_GROUPS, 1, maximum beats per search; MAX_GROUPS >= 1.
- Derived, not overridable: L = ceil(log2(N)) tree stages; IW = max(1, ceil(log2(N*MAX_GROUPS))) global index width; GW = max(1, ceil(log2(MAX_GROUPS))) group counter width.

Ports:
- iClock  in  1  rising-edge clock.
- iReset  in  1  synchronous, active-high reset.
- iEnable  in  1  clock enable; when low every register, including the valid pipeline, holds.
- iValid  in  1  beat on iIn is valid; sampled only when iEnable=1.
- iLast  in  1  qualifies a valid beat as the final group of a search.
- iIn  in  N*W  packed costs; element k = iIn[k*W +: W], local index k.
- oValid  out  1  one-cycle pulse (per enabled cycle) carrying a search result.
- oMinimum  out  IW  global index of the minimum: group*N + local index.
- oValue  out  W  minimum cost value.
- oOverflow  out  1  valid with oValid; the search exceeded MAX_GROUPS beats.

Behaviour:
- Reset: every output is 0 and all pipeline valid bits are cleared. The accumulator value is set to all-ones, the accumulator index, group counter and overflow flag to 0. Data already in flight is discarded, and a search interrupted by reset produces no output.
- Tree:
  - L registered stages. Stage s pairs adjacent survivors (2j, 2j+1); an odd leftover survivor is registered unchanged (pass-through) into the next stage.
  - Compare rule: right wins only if strictly less than left. Ties therefore resolve to the lowest index.
  - Each stage carries {value, local index, valid, last}.
- Accumulator stage (one register stage after the tree), acting when the tree-output valid = 1 and iEnable = 1:
  - Candidate global index = grp*N + local index.
  - The candidate replaces the accumulator only if its value < acc value, or if it is the first beat of the search (grp = 0). Ties keep the earlier group.
  - Not last: grp increments, saturating at MAX_GROUPS-1. An increment attempted at saturation sets the overflow flag; overflowing beats still take part in the comparison with the saturated grp.
  - Last: oValid=1 and oMinimum/oValue take the final winner (after including this beat). oOverflow = flag. grp, flag and acc reset for the next search.
- Outputs hold their last values between oValid pulses; oValid is otherwise 0.
- Latency: L+1 enabled cycles from iValid&iLast to oValid. Stall cycles (iEnable=0) add exactly one cycle each.
- Throughput: one beat per enabled cycle, back-to-back searches with no bubble.
- Boundaries:
  - MAX_GROUPS=1 with iLast=1 on every beat gives a plain N-way min with latency L+1.
  - iLast ignored when iValid=0.
  - All-equal inputs give index 0.
  - A value of all-ones is a legal candidate.
  - A search of one beat with iLast=1 is legal at any MAX_GROUPS.

Decomposition:
- Package min_index_pkg holds the clog2 helper function and the derived-width calculations for L, IW and GW.
- One natural sub-module: min_index_stage. It is a generic registered pairwise-reduce level (input count M, output ceil(M/2)) with enable, reset and valid/last sideband. The top generate-loops it L times, then adds the accumulator.

Test Plan:
- N=12, W=28, MAX_GROUPS=1: inputs k -> 100-k, valid+last for one beat -> after 5 cycles oValid=1, oMinimum=11, oValue=89.
- Ties: N=12, all inputs = 7 -> oMinimum=0, oValue=7; inputs 3 and 9 = 5, rest 50 -> oMinimum=3.
- Odd N=5, W=8: inputs {9,8,7,6,2} -> latency 4 (L=3), oMinimum=4, oValue=2, which checks the pass-through path.
- Multi-group, N=4, MAX_GROUPS=4: beats {40,41,42,43}, {30,31,5,33}, {5,9,9,9} + last -> oMinimum=6, oValue=5 (earlier group wins the tie), oOverflow=0. A fifth beat in a second search -> oOverflow=1.
- Stall and back-to-back: run the N=12 searches of the first scenario with iEnable low for 2 cycles mid-pipeline -> oValid delayed by exactly 2 cycles. Two consecutive searches produce two oValid pulses on consecutive enabled cycles with the correct indices.
- Reset mid-search: N=4, MAX_GROUPS=4, issue two non-last beats, assert iReset for 1 cycle, then one beat {1,2,3,0} + last -> oMinimum=3 (grp restarted at 0), no spurious oValid from the aborted search.
